// File: rtl/pae32_ptw.sv
// pae32_ptw: single-walk page-table walker for the PAE32 translator.
// Fetches one PTE per I/D miss, then refills a TLB or reports a fault.
module pae32_ptw #(
  parameter int TIMEOUT = 64,
  parameter int TCW     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iptemiss,
  input  logic        dptemiss,
  input  logic [7:0]  iva_h8,
  input  logic [7:0]  dva_h8,
  input  logic [21:0] iptbr,
  input  logic [21:0] dptbr,
  input  logic        supervisor_mode,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic        tlb_dside,
  output logic [7:0]  tlb_tag,
  output logic [15:0] tlb_pa_h16,
  output logic [3:0]  tlb_attr,
  output logic        pf_valid,
  input  logic        pf_ack,
  output logic        pf_dside,
  output logic [7:0]  pf_va_h8,
  output logic [1:0]  pf_cause,
  output logic        walk_busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CHECK,
    REFILL,
    FAULT
  } state_t;

  localparam logic [TCW-1:0] CNT_MAX = TCW'(TIMEOUT - 1);

  state_t         state;
  logic           side_q;
  logic [7:0]     va_q;
  logic [15:0]    pa_q;
  logic [3:0]     attr_q;
  logic [TCW-1:0] cnt_q;

  // PTE[15:4] carries nothing the TLB stores.
  logic unused_pte;
  assign unused_pte = ^mem_rdata[15:4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      side_q     <= 1'b0;
      va_q       <= '0;
      pa_q       <= '0;
      attr_q     <= '0;
      cnt_q      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      tlb_we     <= 1'b0;
      tlb_dside  <= 1'b0;
      tlb_tag    <= '0;
      tlb_pa_h16 <= '0;
      tlb_attr   <= '0;
      pf_valid   <= 1'b0;
      pf_dside   <= 1'b0;
      pf_va_h8   <= '0;
      pf_cause   <= '0;
      walk_busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dptemiss || iptemiss) begin
            state     <= REQ;
            side_q    <= dptemiss;
            va_q      <= dptemiss ? dva_h8 : iva_h8;
            mem_addr  <= dptemiss ? {dptbr, dva_h8, 2'b00}
                                  : {iptbr, iva_h8, 2'b00};
            mem_req   <= 1'b1;
            walk_busy <= 1'b1;
            cnt_q     <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state    <= CHECK;
            pa_q     <= mem_rdata[31:16];
            attr_q   <= mem_rdata[3:0];
            cnt_q    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state    <= FAULT;
            cnt_q    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            pf_valid <= 1'b1;
            pf_dside <= side_q;
            pf_va_h8 <= va_q;
            pf_cause <= 2'b10;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHECK: begin
          unique case (1'b1)
            !attr_q[0]: begin
              state    <= FAULT;
              pf_valid <= 1'b1;
              pf_dside <= side_q;
              pf_va_h8 <= va_q;
              pf_cause <= 2'b01;
            end
            attr_q[0] && !attr_q[2] && !supervisor_mode: begin
              state    <= FAULT;
              pf_valid <= 1'b1;
              pf_dside <= side_q;
              pf_va_h8 <= va_q;
              pf_cause <= 2'b11;
            end
            default: begin
              state      <= REFILL;
              tlb_we     <= 1'b1;
              tlb_dside  <= side_q;
              tlb_tag    <= va_q;
              tlb_pa_h16 <= pa_q;
              tlb_attr   <= attr_q;
            end
          endcase
        end
        REFILL: begin
          state      <= IDLE;
          tlb_we     <= 1'b0;
          tlb_dside  <= 1'b0;
          tlb_tag    <= '0;
          tlb_pa_h16 <= '0;
          tlb_attr   <= '0;
          walk_busy  <= 1'b0;
        end
        FAULT: begin
          if (pf_ack) begin
            state     <= IDLE;
            pf_valid  <= 1'b0;
            pf_dside  <= 1'b0;
            pf_va_h8  <= '0;
            pf_cause  <= '0;
            walk_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pae32_ptw.sv
// tb_pae32_ptw: randomized walks checked against a transaction-level
// model of the walker's outcome, address and timing.
module tb_pae32_ptw;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iptemiss, dptemiss;
  logic [7:0]  iva_h8, dva_h8;
  logic [21:0] iptbr, dptbr;
  logic        supervisor_mode;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        tlb_we, tlb_dside;
  logic [7:0]  tlb_tag;
  logic [15:0] tlb_pa_h16;
  logic [3:0]  tlb_attr;
  logic        pf_valid, pf_ack, pf_dside;
  logic [7:0]  pf_va_h8;
  logic [1:0]  pf_cause;
  logic        walk_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pae32_ptw #(.TIMEOUT(TO), .TCW(7)) dut (
    .clk(clk), .rst(rst),
    .iptemiss(iptemiss), .dptemiss(dptemiss),
    .iva_h8(iva_h8), .dva_h8(dva_h8),
    .iptbr(iptbr), .dptbr(dptbr),
    .supervisor_mode(supervisor_mode),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .tlb_we(tlb_we), .tlb_dside(tlb_dside),
    .tlb_tag(tlb_tag), .tlb_pa_h16(tlb_pa_h16),
    .tlb_attr(tlb_attr),
    .pf_valid(pf_valid), .pf_ack(pf_ack),
    .pf_dside(pf_dside), .pf_va_h8(pf_va_h8),
    .pf_cause(pf_cause), .walk_busy(walk_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outcome of one walk: cause 0 = refill, else fault cause.
  // cyc = cycle (miss sampled at 0) where tlb_we / pf_valid shows.
  typedef struct {
    logic [1:0] cause;
    int         cyc;
  } res_t;

  function automatic res_t model(input logic [31:0] pte,
                                 input bit sup, input int d);
    res_t r;
    if (d >= TO) begin
      r.cause = 2'b10; r.cyc = TO + 1;
    end else begin
      r.cyc = d + 3;
      if (!pte[0]) r.cause = 2'b01;
      else if (!pte[2] && !sup) r.cause = 2'b11;
      else r.cause = 2'b00;
    end
    return r;
  endfunction

  task automatic do_walk(input bit ds, input logic [7:0] va,
                         input logic [21:0] base,
                         input logic [31:0] pte, input bit sup,
                         input int d, input int hold);
    res_t r;
    int we_cyc, pf_cyc, nwe, held;
    bit addr_bad, zero_bad;
    logic [31:0] ea;
    logic [31:0] we_f, pf_f;
    r  = model(pte, sup, d);
    ea = {base, va, 2'b00};
    we_cyc = 0; pf_cyc = 0; nwe = 0; held = 0;
    addr_bad = 0; zero_bad = 0; we_f = '0; pf_f = '0;
    @(negedge clk);
    supervisor_mode = sup;
    if (ds) begin
      dptemiss = 1; dva_h8 = va; dptbr = base;
      iva_h8 = 8'($urandom); iptbr = 22'($urandom);
    end else begin
      iptemiss = 1; iva_h8 = va; iptbr = base;
      dva_h8 = 8'($urandom); dptbr = 22'($urandom);
    end
    for (int k = 1; k <= TO + d + hold + 20; k++) begin
      @(negedge clk);
      pf_ack    = 0;
      mem_ack   = (k == d + 1);
      mem_rdata = mem_ack ? pte : $urandom;
      if (k <= d + 1 && k <= TO)
        if (mem_req !== 1'b1 || mem_addr !== ea) addr_bad = 1;
      if (!tlb_we && {tlb_dside, tlb_tag, tlb_pa_h16, tlb_attr} != 0)
        zero_bad = 1;
      if (tlb_we) begin
        nwe++;
        if (we_cyc == 0) begin
          we_cyc = k;
          we_f = {3'b0, tlb_dside, tlb_tag, tlb_pa_h16, tlb_attr};
        end
        iptemiss = 0; dptemiss = 0;
      end
      if (pf_valid) begin
        if (pf_cyc == 0) begin
          pf_cyc = k;
          pf_f = {21'b0, pf_dside, pf_va_h8, pf_cause};
        end
        held++;
        if (held == hold) begin
          pf_ack = 1; iptemiss = 0; dptemiss = 0;
        end
      end
      if (!walk_busy && (we_cyc != 0 || pf_cyc != 0)) break;
    end
    mem_ack = 0; pf_ack = 0; iptemiss = 0; dptemiss = 0;
    check("req_addr", 32'(addr_bad), 0);
    check("tlb_zero", 32'(zero_bad), 0);
    if (r.cause == 2'b00) begin
      check("we_cycle", we_cyc, r.cyc);
      check("we_count", nwe, 1);
      check("no_pf", pf_cyc, 0);
      check("tlb_fields", we_f,
            {3'b0, ds, va, pte[31:16], pte[3:0]});
    end else begin
      check("pf_cycle", pf_cyc, r.cyc);
      check("no_we", nwe, 0);
      check("pf_fields", pf_f, {21'b0, ds, va, r.cause});
      check("pf_held", held, hold);
    end
    check("idle_busy", walk_busy, 0);
  endtask

  task automatic dual_walk(input logic [7:0] iva, input logic [7:0] dva,
                           input logic [21:0] ib, input logic [21:0] db);
    logic [31:0] aq[$];
    logic [8:0]  wq[$];
    @(negedge clk);
    supervisor_mode = 1;
    iptemiss = 1; iva_h8 = iva; iptbr = ib;
    dptemiss = 1; dva_h8 = dva; dptbr = db;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      mem_ack   = mem_req;
      mem_rdata = 32'h5A5A_0005;
      if (mem_req) aq.push_back(mem_addr);
      if (tlb_we) begin
        wq.push_back({tlb_dside, tlb_tag});
        if (tlb_dside) dptemiss = 0;
        else iptemiss = 0;
      end
      if (!iptemiss && !dptemiss && !walk_busy) break;
    end
    mem_ack = 0; iptemiss = 0; dptemiss = 0;
    check("dual_nreq", aq.size(), 2);
    check("dual_nwe", wq.size(), 2);
    if (aq.size() == 2) begin
      check("dual_addr0", aq[0], {db, dva, 2'b00});
      check("dual_addr1", aq[1], {ib, iva, 2'b00});
    end
    if (wq.size() == 2) begin
      check("dual_we0", 32'(wq[0]), 32'({1'b1, dva}));
      check("dual_we1", 32'(wq[1]), 32'({1'b0, iva}));
    end
  endtask

  task automatic reset_in_req();
    bit bad;
    bad = 0;
    @(negedge clk);
    supervisor_mode = 1;
    dptemiss = 1; dva_h8 = 8'h33; dptbr = 22'h00_1234;
    @(negedge clk);
    check("rst_pre_req", mem_req, 1);
    #2 rst = 0;
    #1;
    check("rst_req_drop", mem_req, 0);
    check("rst_busy_drop", walk_busy, 0);
    dptemiss = 0;
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mem_ack   = 1'($urandom);
      mem_rdata = 32'hFFFF_0007;
      if (tlb_we || pf_valid || walk_busy || mem_req) bad = 1;
    end
    mem_ack = 0;
    check("rst_quiet", 32'(bad), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pte;
    rst = 0;
    iptemiss = 0; dptemiss = 0;
    iva_h8 = 0; dva_h8 = 0; iptbr = 0; dptbr = 0;
    supervisor_mode = 0;
    mem_ack = 0; mem_rdata = 0; pf_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {mem_req, tlb_we, pf_valid, walk_busy}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_pf", {pf_dside, pf_va_h8, pf_cause}, 0);
    rst = 1;

    do_walk(1, 8'h12, 22'h00_0400, 32'hABCD_0007, 0, 0, 1);
    dual_walk(8'h21, 8'h87, 22'h01_5555, 22'h2A_AAAA);
    do_walk(0, 8'h44, 22'h00_0100, 32'h1234_0000, 1, 1, 5);
    do_walk(1, 8'h55, 22'h3F_0001, 32'h1234_0003, 0, 0, 2);
    do_walk(1, 8'h55, 22'h3F_0001, 32'h1234_0003, 1, 0, 2);
    do_walk(0, 8'h66, 22'h00_0F00, 32'h9999_000F, 1, TO + 2, 3);
    do_walk(0, 8'h66, 22'h00_0F00, 32'h9999_000F, 1, TO - 1, 3);
    reset_in_req();

    for (int i = 0; i < 40; i++) begin
      pte = $urandom;
      do_walk(1'($urandom), 8'($urandom), 22'($urandom), pte,
              1'($urandom), $urandom_range(0, TO + 1),
              $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
